// File: rtl/clk_cs_xfer_ctrl.sv
// Round-robin transfer controller for the clk_cs divider: arbitrates two requesters and
// runs one MSB-first serial transfer per grant, gating the divider through o_clk_cs_en.
`ifndef CLK_CS_ENABLE
`define CLK_CS_ENABLE 1'b1
`endif

module clk_cs_xfer_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_done0,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic              o_clk_cs_en,
    input  logic              i_clk_cs,
    output logic              o_cs_n,
    output logic              o_mosi,
    input  logic              i_miso
);

    localparam int unsigned CNT_MAX = (SETUP_CYC > HOLD_CYC) ?
                                      ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                                      ((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BC_W    = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [BC_W-1:0]   r_bitcnt;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic              r_clk_cs_d;
    logic              r_owner;
    logic              r_rr;
    logic              w_rise;
    logic              w_fall;
    logic              w_last_fall;
    logic              w_accept;
    logic              w_pick1;
    logic              w_hold_last;

    assign w_rise      = i_clk_cs & ~r_clk_cs_d;
    assign w_fall      = ~i_clk_cs & r_clk_cs_d;
    assign w_last_fall = w_fall & (r_bitcnt == BC_W'(DATA_W));
    // r_rr set means req1 is favoured when both requesters compete
    assign w_pick1     = i_req1 & (~i_req0 | r_rr);
    assign o_mosi      = r_tx[DATA_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_clk_cs_en = ~`CLK_CS_ENABLE;
        w_accept    = 1'b0;
        w_hold_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((i_req0 | i_req1) & ~i_clk_cs) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Dropped in the cycle of the last fall so the divider parks at 0
                if (!w_last_fall) begin
                    o_clk_cs_en = `CLK_CS_ENABLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                    w_hold_last = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, handshake pulses and serial pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_clk_cs_d <= 1'b0;
            r_owner    <= 1'b0;
            r_rr       <= 1'b0;
            o_gnt0     <= 1'b0;
            o_gnt1     <= 1'b0;
            o_done0    <= 1'b0;
            o_done1    <= 1'b0;
            o_rdata    <= '0;
            o_busy     <= 1'b0;
            o_cs_n     <= 1'b1;
        end else begin
            r_clk_cs_d <= i_clk_cs;
            o_gnt0     <= 1'b0;
            o_gnt1     <= 1'b0;
            o_done0    <= 1'b0;
            o_done1    <= 1'b0;
            o_busy     <= (w_state_nxt != S_IDLE);
            r_cnt      <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);

            if (w_accept) begin
                o_gnt0   <= ~w_pick1;
                o_gnt1   <= w_pick1;
                r_tx     <= w_pick1 ? i_wdata1 : i_wdata0;
                r_owner  <= w_pick1;
                r_bitcnt <= '0;
                o_cs_n   <= 1'b0;
            end

            if (r_state == S_SHIFT) begin
                if (w_rise) begin
                    r_rx     <= {r_rx[DATA_W-2:0], i_miso};
                    r_bitcnt <= r_bitcnt + BC_W'(1);
                end
                if (w_fall && (r_bitcnt < BC_W'(DATA_W))) begin
                    r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                end
            end

            if (w_hold_last) begin
                o_cs_n  <= 1'b1;
                o_rdata <= r_rx;
                o_done0 <= ~r_owner;
                o_done1 <= r_owner;
                r_rr    <= ~r_owner;
            end
        end
    end

endmodule

// File: tb/tb_clk_cs_xfer_ctrl.sv
// Bench for clk_cs_xfer_ctrl: /4 divider model, MSB-first slave model, per-requester
// expected-word queues checked by a monitor on every done pulse.
module tb_clk_cs_xfer_ctrl;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned SETUP_CYC = 2;
    localparam int unsigned HOLD_CYC  = 2;
    localparam int unsigned GAP_CYC   = 2;
    localparam int unsigned CS_LOW    = SETUP_CYC + 4 * DATA_W + 1 + HOLD_CYC;
    localparam logic [7:0]  MISO_XOR  = 8'h99;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, done0, done1, busy, clk_cs_en, cs_n, mosi;
    logic [7:0] rdata;
    logic       clk_cs;
    logic       miso = 1'b0;
    logic       dv_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    int         mon_nrise, mon_cs_lo, mon_cs_hi, mon_toggles;
    int         n_gnt0, n_gnt1, n_done0, n_done1;
    logic       mon_act, mon_owner, mon_prev;
    logic [7:0] mon_cap, mon_sreg, mon_exp;

    clk_cs_xfer_ctrl #(
        .DATA_W(DATA_W), .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req0(req0), .i_req1(req1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
        .o_rdata(rdata), .o_busy(busy), .o_clk_cs_en(clk_cs_en),
        .i_clk_cs(clk_cs), .o_cs_n(cs_n), .o_mosi(mosi), .i_miso(miso)
    );

    always #5 clk = ~clk;

    // clk_div model: toggles every second clk while enabled, parks at 0 when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_cnt <= 1'b0;
            clk_cs <= 1'b0;
        end else if (clk_cs_en !== 1'b1) begin
            dv_cnt <= 1'b0;
            clk_cs <= 1'b0;
        end else if (dv_cnt) begin
            dv_cnt <= 1'b0;
            clk_cs <= ~clk_cs;
        end else begin
            dv_cnt <= 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: slave model, pin capture, scoreboard pop on done
    always @(negedge clk) begin
        logic rise, fall;
        if (rst) begin
            mon_act   = 1'b0;
            mon_cs_hi = 100;
            mon_nrise = 0;
            mon_prev  = clk_cs;
        end else begin
            rise = clk_cs & ~mon_prev;
            fall = ~clk_cs & mon_prev;
            if (cs_n && (rise || fall)) mon_toggles++;
            if (gnt0 || gnt1) begin
                if (gnt0) n_gnt0++;
                if (gnt1) n_gnt1++;
                checks++;
                if (gnt0 && gnt1) begin
                    errors++;
                    $display("FAIL gnt_onehot: got gnt0=%b gnt1=%b expected one", gnt0, gnt1);
                end
                checks++;
                if (mon_cs_hi < int'(GAP_CYC)) begin
                    errors++;
                    $display("FAIL gap_before_gnt: got %0d cycles cs_n high expected >= %0d", mon_cs_hi, GAP_CYC);
                end
                mon_owner = gnt1;
                if ((gnt1 && q1.size() == 0) || (!gnt1 && q0.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gnt: got grant to %0d expected none", gnt1);
                    mon_sreg = '0;
                end else begin
                    mon_sreg = (gnt1 ? q1[0] : q0[0]) ^ MISO_XOR;
                end
                miso      = mon_sreg[7];
                mon_act   = 1'b1;
                mon_cap   = '0;
                mon_nrise = 0;
                mon_cs_lo = 0;
                mon_cs_hi = 0;
            end
            if (!cs_n) mon_cs_lo++;
            else mon_cs_hi++;
            if (rise) begin
                mon_cap = {mon_cap[6:0], mosi};
                mon_nrise++;
            end
            if (fall) begin
                mon_sreg = {mon_sreg[6:0], 1'b0};
                miso     = mon_sreg[7];
            end
            if (done0 || done1) begin
                if (done0) n_done0++;
                if (done1) n_done1++;
                checks++;
                if (!mon_act || (done0 && done1) || (done1 !== mon_owner)) begin
                    errors++;
                    $display("FAIL done_owner: got done0=%b done1=%b expected owner %0d active %b",
                             done0, done1, mon_owner, mon_act);
                end
                if ((done1 && q1.size() == 0) || (!done1 && q0.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL done_queue: got done for %0d expected no pending transfer", done1);
                end else begin
                    mon_exp = done1 ? q1.pop_front() : q0.pop_front();
                    checks++;
                    if (rdata !== (mon_exp ^ MISO_XOR)) begin
                        errors++;
                        $display("FAIL rdata: got %h expected %h", rdata, mon_exp ^ MISO_XOR);
                    end
                    checks++;
                    if (mon_cap !== mon_exp) begin
                        errors++;
                        $display("FAIL mosi_bits: got %h expected %h", mon_cap, mon_exp);
                    end
                end
                checks++;
                if (mon_nrise != int'(DATA_W)) begin
                    errors++;
                    $display("FAIL rise_count: got %0d expected %0d", mon_nrise, DATA_W);
                end
                checks++;
                if (mon_cs_lo != int'(CS_LOW)) begin
                    errors++;
                    $display("FAIL cs_low_time: got %0d expected %0d", mon_cs_lo, CS_LOW);
                end
                checks++;
                if (mon_toggles != 0) begin
                    errors++;
                    $display("FAIL idle_toggle: got %0d clk_cs edges with cs_n high expected 0", mon_toggles);
                end
                mon_act = 1'b0;
            end
            mon_prev = clk_cs;
        end
    end

    task automatic wait_gnt(output logic g0, output logic g1);
        g0 = 1'b0;
        g1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                g0 = gnt0;
                g1 = gnt1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_gnt: got no grant expected one within 400 cycles");
    endtask

    task automatic wait_done(input logic x);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((x && done1) || (!x && done0)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done: got no done%0d expected one within 400 cycles", x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        q0.delete();
        q1.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b expected 1", cs_n); end
        checks++;
        if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b expected 0", mosi); end
        checks++;
        if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
            errors++; $display("FAIL rst_pulses: got %b expected 0000", {gnt0, gnt1, done0, done1});
        end
        checks++;
        if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h expected 00", rdata); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++;
        if (clk_cs_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", clk_cs_en); end
    endtask

    task automatic test_single_xfer();
        logic g0, g1;
        wdata0 = 8'hA5;
        q0.push_back(8'hA5);
        req0 = 1'b1;
        wait_gnt(g0, g1);
        checks++;
        if (!(g0 && !g1)) begin errors++; $display("FAIL t1_gnt: got gnt0=%b gnt1=%b expected 1 0", g0, g1); end
        req0 = 1'b0;
        wait_done(1'b0);
        checks++;
        if (rdata !== 8'h3C) begin errors++; $display("FAIL t1_rdata: got %h expected 3c", rdata); end
        repeat (3) @(negedge clk);
        checks++;
        if (clk_cs !== 1'b0) begin errors++; $display("FAIL t1_clk_cs_idle: got %b expected 0", clk_cs); end
        checks++;
        if (busy !== 1'b0 || cs_n !== 1'b1) begin
            errors++; $display("FAIL t1_idle: got busy=%b cs_n=%b expected 0 1", busy, cs_n);
        end
    endtask

    task automatic test_arbitration();
        logic g0, g1;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            wdata0 = 8'h11 + 8'(r * 34);
            wdata1 = 8'h22 + 8'(r * 34);
            q0.push_back(wdata0);
            q1.push_back(wdata1);
            req0 = 1'b1;
            req1 = 1'b1;
            wait_gnt(g0, g1);
            checks++;
            if (!(g0 && !g1)) begin errors++; $display("FAIL t2_first_gnt%0d: got gnt0=%b gnt1=%b expected 1 0", r, g0, g1); end
            req0 = 1'b0;
            wait_gnt(g0, g1);
            checks++;
            if (!(g1 && !g0)) begin errors++; $display("FAIL t2_second_gnt%0d: got gnt0=%b gnt1=%b expected 0 1", r, g0, g1); end
            req1 = 1'b0;
            wait_done(1'b1);
        end
    endtask

    task automatic test_back_to_back();
        logic g0, g1;
        wdata1 = 8'h5A;
        q1.push_back(wdata1);
        req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(g0, g1);
            checks++;
            if (!(g1 && !g0)) begin errors++; $display("FAIL t3_gnt%0d: got gnt0=%b gnt1=%b expected 0 1", k, g0, g1); end
            if (k < 2) begin
                wdata1 = wdata1 + 8'h37;
                q1.push_back(wdata1);
            end else begin
                req1 = 1'b0;
            end
        end
        wait_done(1'b1);
    endtask

    task automatic test_reset_mid();
        logic g0, g1;
        int   d0;
        logic hit;
        wdata0 = 8'hC3;
        q0.push_back(wdata0);
        req0 = 1'b1;
        wait_gnt(g0, g1);
        req0 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            if (mon_nrise >= 3) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL t4_three_rises: got %0d rises expected 3", mon_nrise); end
        d0 = n_done0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        void'(q0.pop_back());
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cs_n !== 1'b1 || clk_cs_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL t4_after_rst: got cs_n=%b en=%b busy=%b expected 1 0 0", cs_n, clk_cs_en, busy);
        end
        checks++;
        if (rdata !== 8'h00) begin errors++; $display("FAIL t4_rdata: got %h expected 00", rdata); end
        repeat (60) @(negedge clk);
        checks++;
        if (n_done0 != d0) begin errors++; $display("FAIL t4_no_done: got %0d dones expected %0d", n_done0, d0); end
        wdata0 = 8'h96;
        q0.push_back(wdata0);
        req0 = 1'b1;
        wait_gnt(g0, g1);
        checks++;
        if (!(g0 && !g1)) begin errors++; $display("FAIL t4_regnt: got gnt0=%b gnt1=%b expected 1 0", g0, g1); end
        req0 = 1'b0;
        wait_done(1'b0);
    endtask

    task automatic test_random();
        logic g0, g1, x;
        for (int i = 0; i < 100; i++) begin
            x = 1'($urandom_range(0, 1));
            if (x) begin
                wdata1 = 8'($urandom);
                q1.push_back(wdata1);
                req1 = 1'b1;
            end else begin
                wdata0 = 8'($urandom);
                q0.push_back(wdata0);
                req0 = 1'b1;
            end
            wait_gnt(g0, g1);
            checks++;
            if ((g1 !== x) || (g0 !== ~x)) begin
                errors++; $display("FAIL t5_gnt%0d: got gnt0=%b gnt1=%b expected requester %0d", i, g0, g1, x);
            end
            req0 = 1'b0;
            req1 = 1'b0;
            wait_done(x);
        end
    endtask

    task automatic test_drop();
        logic g0, g1;
        int   ng0, nd0;
        wdata1 = 8'h0F;
        q1.push_back(wdata1);
        req1 = 1'b1;
        wait_gnt(g0, g1);
        req1 = 1'b0;
        wait_done(1'b1);
        ng0    = n_gnt0;
        nd0    = n_done0;
        wdata0 = 8'hEE;
        wdata1 = 8'hF0;
        q1.push_back(wdata1);
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        wait_gnt(g0, g1);
        checks++;
        if (!(g1 && !g0)) begin errors++; $display("FAIL t6_gnt: got gnt0=%b gnt1=%b expected 0 1", g0, g1); end
        req1 = 1'b0;
        wait_done(1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (n_gnt0 != ng0 || n_done0 != nd0) begin
            errors++; $display("FAIL t6_no_req0: got gnt0 %0d done0 %0d expected %0d %0d", n_gnt0, n_done0, ng0, nd0);
        end
    endtask

    initial begin
        mon_toggles = 0;
        n_gnt0 = 0; n_gnt1 = 0; n_done0 = 0; n_done1 = 0;
        test_reset();
        test_single_xfer();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
